irda_dma_arbiter: RTL and testbench

IRDA_DMA_ARBITER -- requirements
Module: irda_dma_arbiter

---
 rtl/irda_dma_arbiter.sv | 95 +++++++++
 tb/tb_irda_dma_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/irda_dma_arbiter.sv
// irda_dma_arbiter: shares one DMA channel between IrDA TX FIFO fill and RX FIFO drain bursts.
//   clk                  : sole clock, all state on rising edge
//   wb_rst_i             : asynchronous active-low reset
//   use_dma              : DMA mode enable
//   txfifo_count/rxfifo_count : FIFO occupancy (0..16)
//   txfifo_trigger_level/rxfifo_trigger_level : FCR trigger level selects
//   fifo_clear           : FIFO clear pulse, aborts a burst and suppresses its strobe
//   dma_ack_i            : one word transferred this cycle
//   dma_req_o/dma_dir_o  : registered channel request and direction (1 = TX fill)
//   txfifo_add/rxfifo_remove : one-cycle FIFO push/pop strobes
//   busy_o               : arbiter not idle
// Optional feature: define IRDA_DMA_RX_PRIORITY_EN to make RX always win a tie
// (overrun protection) instead of round-robin.
module irda_dma_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             wb_rst_i,
    input  logic             use_dma,
    input  logic [CNT_W-1:0] txfifo_count,
    input  logic [CNT_W-1:0] rxfifo_count,
    input  logic [1:0]       txfifo_trigger_level,
    input  logic [1:0]       rxfifo_trigger_level,
    input  logic             fifo_clear,
    input  logic             dma_ack_i,
    output logic             dma_req_o,
    output logic             dma_dir_o,
    output logic             txfifo_add,
    output logic             rxfifo_remove,
    output logic             busy_o
);
    typedef enum logic [1:0] {IDLE, TX_BURST, RX_BURST, GAP} state_t;
    state_t           state, state_nx;
    logic [4:0]       beats;
    logic [CNT_W-1:0] txt, rxt;
    logic             tx_need, rx_need, in_burst, is_tx, burst_end, pick_tx;
    // TX thresholds 0,4,8,12 are simply level*4
    assign txt = CNT_W'({txfifo_trigger_level, 2'b00});
    assign rxt = rxfifo_trigger_level == 2'b00 ? CNT_W'(1) :
                 rxfifo_trigger_level == 2'b11 ? CNT_W'(14) :
                 CNT_W'({rxfifo_trigger_level, 2'b00});
    assign tx_need  = use_dma & (txfifo_count <= txt);
    assign rx_need  = use_dma & (rxfifo_count >= rxt);
    assign in_burst = (state == TX_BURST) | (state == RX_BURST);
    assign is_tx    = state == TX_BURST;
    // Stop one word short of TX full (15) or at the last RX word (1)
    assign burst_end = in_burst & (~use_dma | fifo_clear |
                       (dma_ack_i & (((beats + 5'd1) == 5'(BURST_LEN)) |
                        (is_tx ? txfifo_count == CNT_W'(15) : rxfifo_count == CNT_W'(1)))));
    assign txfifo_add    = is_tx & dma_ack_i & ~fifo_clear;
    assign rxfifo_remove = (state == RX_BURST) & dma_ack_i & ~fifo_clear;
    assign busy_o        = state != IDLE;
`ifdef IRDA_DMA_RX_PRIORITY_EN
    assign pick_tx = 1'b0;
`else
    // tx_turn is the round-robin flag: reset 0 gives RX the first tie,
    // each GAP hands the next tie to the direction just not served
    logic tx_turn, cur_tx;
    assign pick_tx = tx_turn;
    always_ff @(posedge clk or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            tx_turn <= 1'b0;
            cur_tx  <= 1'b0;
        end else begin
            cur_tx  <= state == IDLE ? state_nx == TX_BURST : cur_tx;
            tx_turn <= state == GAP ? ~cur_tx : tx_turn;
        end
    end
`endif
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = (tx_need & (~rx_need | pick_tx)) ? TX_BURST :
                                 rx_need ? RX_BURST : IDLE;
            TX_BURST,
            RX_BURST: state_nx = burst_end ? GAP : state;
            GAP:      state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state     <= IDLE;
            beats     <= 5'd0;
            dma_req_o <= 1'b0;
            dma_dir_o <= 1'b0;
        end else begin
            state     <= state_nx;
            beats     <= state == GAP ? 5'd0 : beats + {4'd0, in_burst & dma_ack_i};
            dma_req_o <= in_burst & ~burst_end;
            dma_dir_o <= is_tx & ~burst_end;
        end
    end
endmodule

// File: tb/tb_irda_dma_arbiter.sv
// tb_irda_dma_arbiter: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_irda_dma_arbiter;
    localparam int BL = 4;
`ifdef IRDA_DMA_RX_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif
    logic clk = 1'b0;
    logic wb_rst_i = 1'b0, use_dma = 1'b0, fifo_clear = 1'b0, dma_ack_i = 1'b0;
    logic [4:0] txfifo_count = '0, rxfifo_count = '0;
    logic [1:0] txfifo_trigger_level = '0, rxfifo_trigger_level = '0;
    logic dma_req_o, dma_dir_o, txfifo_add, rxfifo_remove, busy_o;

    irda_dma_arbiter #(.BURST_LEN(BL), .CNT_W(5)) dut (
        .clk(clk), .wb_rst_i(wb_rst_i), .use_dma(use_dma),
        .txfifo_count(txfifo_count), .rxfifo_count(rxfifo_count),
        .txfifo_trigger_level(txfifo_trigger_level), .rxfifo_trigger_level(rxfifo_trigger_level),
        .fifo_clear(fifo_clear), .dma_ack_i(dma_ack_i),
        .dma_req_o(dma_req_o), .dma_dir_o(dma_dir_o),
        .txfifo_add(txfifo_add), .rxfifo_remove(rxfifo_remove), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int n_add, n_rem;
    bit prev_req;
    bit dirs[$];

    // stimulus
    bit s_rstn, s_use, s_clr, s_ack, emu;
    int s_txc, s_rxc, s_txl, s_rxl;

    // behavioural model: phase 0 idle, 1 TX burst, 2 RX burst, 3 gap
    int TXT[4] = '{0, 4, 8, 12};
    int RXT[4] = '{1, 4, 8, 14};
    int m_phase, m_words;
    bit m_req, m_dir, m_served_tx, m_tx_next;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_phase = 0; m_words = 0; m_req = 0; m_dir = 0; m_served_tx = 0; m_tx_next = 0;
    endfunction

    function automatic void m_step();
        bit tn, rn, done;
        if (m_phase == 0) begin
            tn = s_use && s_txc <= TXT[s_txl];
            rn = s_use && s_rxc >= RXT[s_rxl];
            if (tn || rn) begin
                m_phase = (tn && (!rn || (!PRIO && m_tx_next))) ? 1 : 2;
                m_words = 0;
            end
            m_req = 0;
        end else if (m_phase == 3) begin
            m_phase = 0; m_words = 0; m_req = 0;
            m_tx_next = !m_served_tx;
        end else begin
            done = !s_use || s_clr ||
                   (s_ack && (m_words + 1 == BL || (m_phase == 1 ? s_txc == 15 : s_rxc == 1)));
            if (s_ack) m_words++;
            m_req = !done;
            m_dir = !done && m_phase == 1;
            if (done) begin
                m_served_tx = m_phase == 1;
                m_phase = 3;
            end
        end
    endfunction

    task automatic tick();
        bit e_add, e_rem;
        @(negedge clk);
        wb_rst_i = s_rstn; use_dma = s_use; fifo_clear = s_clr; dma_ack_i = s_ack;
        txfifo_count = 5'(s_txc); rxfifo_count = 5'(s_rxc);
        txfifo_trigger_level = 2'(s_txl); rxfifo_trigger_level = 2'(s_rxl);
        #1;
        if (!s_rstn) m_reset();
        e_add = m_phase == 1 && s_ack && !s_clr;
        e_rem = m_phase == 2 && s_ack && !s_clr;
        check("txfifo_add", txfifo_add, e_add);
        check("rxfifo_remove", rxfifo_remove, e_rem);
        check("busy", busy_o, m_phase != 0);
        check("dma_req", dma_req_o, m_req);
        if (m_req) check("dma_dir", dma_dir_o, m_dir);
        check("strobe_excl", txfifo_add & rxfifo_remove, 0);
        n_add += int'(txfifo_add);
        n_rem += int'(rxfifo_remove);
        if (dma_req_o && !prev_req) dirs.push_back(dma_dir_o);
        prev_req = dma_req_o;
        @(posedge clk);
        if (!s_rstn) m_reset();
        else m_step();
        if (emu) begin
            if (e_add && s_txc < 16) s_txc++;
            if (e_rem && s_rxc > 0) s_rxc--;
        end
    endtask

    task automatic start(input int txc, input int rxc);
        s_rstn = 0; s_use = 1; s_clr = 0; s_ack = 1; emu = 0;
        s_txc = txc; s_rxc = rxc; s_txl = 0; s_rxl = 0;
        tick();
        s_rstn = 1;
        n_add = 0; n_rem = 0; dirs.delete();
    endtask

    initial begin
        bit exp035[3];
        m_reset();
        prev_req = 0;
        // reset state with busy inputs present
        start(0, 16);
        s_rstn = 0; tick();
        check("reset_strobes", n_add + n_rem, 0);

        // TX fill burst of exactly BURST_LEN words, then re-request
        start(0, 0);
        repeat (7) tick();
        check("tx_burst_adds", n_add, 4);
        repeat (2) tick();
        check("tx_rerequest", dma_req_o, 1);
        check("tx_rerequest_dir", dma_dir_o, 1);

        // RX drain stops when the FIFO is down to its last word
        start(16, 2);
        emu = 1;
        repeat (8) tick();
        check("rx_empty_stop", n_rem, 2);
        check("rx_final_cnt", s_rxc, 0);

        // persistent needs in both directions
        start(0, 16);
        repeat (20) tick();
        exp035 = PRIO ? '{0, 0, 0} : '{0, 1, 0};
        for (int i = 0; i < 3; i++)
            check($sformatf("burst_dir%0d", i), i < dirs.size() ? {31'd0, dirs[i]} : 32'd2, {31'd0, exp035[i]});

        // fifo_clear on the second ack of a TX burst
        start(0, 0);
        repeat (2) tick();
        s_clr = 1; tick();
        s_clr = 0; s_use = 0; tick();
        check("clr_adds", n_add, 1);
        check("clr_req_drop", dma_req_o, 0);

        // asynchronous reset in the middle of an RX burst
        start(16, 16);
        repeat (3) tick();
        @(negedge clk);
        dma_ack_i = 1;
        #1;
        check("pre_reset_rem", rxfifo_remove, 1);
        wb_rst_i = 0;
        #1;
        check("async_req", dma_req_o, 0);
        check("async_dir", dma_dir_o, 0);
        check("async_busy", busy_o, 0);
        check("async_rem", rxfifo_remove, 0);
        check("async_add", txfifo_add, 0);
        m_reset();
        s_rstn = 0; tick();
        s_rstn = 1; s_use = 0; n_rem = 0; n_add = 0;
        repeat (4) tick();
        check("post_reset_quiet", n_add + n_rem, 0);

        // DMA disabled: needs present but no request, acks ignored
        start(0, 16);
        s_use = 0;
        repeat (8) tick();
        check("nodma_strobes", n_add + n_rem, 0);

        // randomized traffic
        start(0, 0);
        for (int i = 0; i < 4000; i++) begin
            s_rstn = $urandom_range(199) != 0;
            s_use  = $urandom_range(9) != 0;
            s_txc  = $urandom_range(16);
            s_rxc  = $urandom_range(16);
            if ($urandom_range(15) == 0) begin
                s_txl = $urandom_range(3);
                s_rxl = $urandom_range(3);
            end
            s_ack = $urandom_range(2) != 0;
            s_clr = $urandom_range(29) == 0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
